// File: rtl/fp_norm_pkg.sv
// fp_norm_pkg - shared constants and types for the FP add/sub normaliser.
//
// Contents:
//   FP_EXP_W / FP_MAN_W / FP_GRS_W : default exponent, fraction and GRS widths
//   sum_w()                        : raw-sum width (carry + hidden + fraction + GRS)
//   norm_res_t                     : stage-2 result record
//
// The record is sized from the package defaults. A build that overrides the
// block widths must override these constants to the same values.
package fp_norm_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_GRS_W = 3;

    function automatic int sum_w(input int man_w, input int grs_w);
        return man_w + grs_w + 2;
    endfunction

    localparam int FP_SUM_W = sum_w(FP_MAN_W, FP_GRS_W);

    typedef struct packed {
        logic                         sign;
        logic [FP_EXP_W-1:0]          exp;
        logic [FP_MAN_W+FP_GRS_W-1:0] frac;
        logic                         zero;
        logic                         underflow;
        logic                         overflow;
    } norm_res_t;

endpackage

// File: rtl/fp_normalize_pipe_if.sv
// fp_normalize_pipe_if - beat interface between mantissa adder, normaliser
// and rounder.
//
// Signals:
//   in_valid/in_ready    : input handshake
//   in_sign/exp/sum      : raw adder result (sum = carry, hidden, frac, GRS)
//   out_valid/out_ready  : output handshake
//   out_sign/exp/frac    : normalised result, GRS kept in frac LSBs
//   out_zero/underflow/overflow : result flags
//
// Modports: master = producer/consumer side (drives inputs, accepts output),
//           slave  = normaliser side.
interface fp_normalize_pipe_if
    import fp_norm_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W,
    parameter int GRS_W = FP_GRS_W
);
    localparam int SUM_W = sum_w(MAN_W, GRS_W);

    logic                   in_valid;
    logic                   in_ready;
    logic                   in_sign;
    logic [EXP_W-1:0]       in_exp;
    logic [SUM_W-1:0]       in_sum;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_sign;
    logic [EXP_W-1:0]       out_exp;
    logic [MAN_W+GRS_W-1:0] out_frac;
    logic                   out_zero;
    logic                   out_underflow;
    logic                   out_overflow;

    modport master (
        output in_valid, in_sign, in_exp, in_sum, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_frac,
               out_zero, out_underflow, out_overflow
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_sum, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_frac,
               out_zero, out_underflow, out_overflow
    );

endinterface

// File: rtl/fp_lzc.sv
// fp_lzc - combinational leading-zero counter built as a binary tree.
//
// Ports:
//   in_i  [WIDTH]              : vector to scan (MSB first)
//   lzc_o [$clog2(WIDTH)+1]    : number of leading zeros, WIDTH when all zero
module fp_lzc #(
    parameter int WIDTH = 27
) (
    input  logic [WIDTH-1:0]            in_i,
    output logic [$clog2(WIDTH):0]      lzc_o
);
    localparam int L  = $clog2(WIDTH);
    localparam int P  = 1 << L;
    localparam int OW = L + 1;

    // Padding with ones below the LSB keeps the tree a power of two without
    // changing the count for any input that holds a one.
    logic [P-1:0] padded;

    always_comb begin
        padded = '1;
        padded[P-1 -: WIDTH] = in_i;
    end

    // Level l holds P>>l nodes; node 0 covers the most significant slice.
    // A node reports "contains a one" and the zero count up to that one.
    for (genvar l = 0; l <= L; l++) begin : g_lvl
        localparam int N = P >> l;
        logic [N-1:0]  vld;
        logic [OW-1:0] cnt [N];

        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < N; i++) begin : g_b
                assign vld[i] = padded[P-1-i];
                assign cnt[i] = '0;
            end
        end else begin : g_node
            for (genvar j = 0; j < N; j++) begin : g_n
                assign vld[j] = g_lvl[l-1].vld[2*j] | g_lvl[l-1].vld[2*j+1];
                assign cnt[j] = g_lvl[l-1].vld[2*j] ? g_lvl[l-1].cnt[2*j]
                              : OW'(1 << (l-1)) + g_lvl[l-1].cnt[2*j+1];
            end
        end
    end

    assign lzc_o = g_lvl[L].vld[0] ? g_lvl[L].cnt[0] : OW'(WIDTH);

endmodule

// File: rtl/fp_normalize_pipe.sv
// fp_normalize_pipe - two-stage normaliser for the FPU add/sub datapath.
//
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset, drops any in-flight beats
//   bus   : fp_normalize_pipe_if.slave (input beat: sign/exp/raw sum,
//           output beat: sign/exp/frac+GRS and zero/underflow/overflow flags)
//
// Stage 1 registers the raw adder result; the leading-zero count of the
// sum below the carry is taken from the registered value. Stage 2 selects
// the normalisation case and registers the result record.
//
// Build option: define FP_NORM_FTZ_EN to flush subnormal results to zero
// (zero and underflow both set).
module fp_normalize_pipe
    import fp_norm_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W,
    parameter int GRS_W = FP_GRS_W
) (
    input  logic               clk,
    input  logic               reset,
    fp_normalize_pipe_if.slave bus
);
    localparam int SUM_W = sum_w(MAN_W, GRS_W);
    localparam int LZC_W = $clog2(SUM_W - 1) + 1;
    localparam logic [EXP_W:0] EXP_SAT = {1'b0, {EXP_W{1'b1}}};

    logic             s1_valid_q;
    logic             s1_sign_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [SUM_W-1:0] s1_sum_q;
    logic [LZC_W-1:0] lzc;

    logic             out_valid_q;
    norm_res_t        res_q, res_d;

    logic             s1_adv, s2_adv;

    logic [SUM_W-1:0] shifted;
    logic [EXP_W:0]   exp_ext, lzc_ext, exp_inc;
    logic [EXP_W-1:0] exp_sub;

    fp_lzc #(.WIDTH(SUM_W - 1)) u_lzc (
        .in_i  (s1_sum_q[SUM_W-2:0]),
        .lzc_o (lzc)
    );

    assign s2_adv      = !out_valid_q || bus.out_ready;
    assign s1_adv      = !s1_valid_q || s2_adv;
    assign bus.in_ready = s1_adv;

    assign exp_ext = {1'b0, s1_exp_q};
    assign lzc_ext = (EXP_W+1)'(lzc);
    assign exp_inc = exp_ext + (EXP_W+1)'(1);
    assign exp_sub = s1_exp_q - EXP_W'(lzc);

    always_comb begin
        res_d      = '0;
        res_d.sign = s1_sign_q;
        shifted    = '0;
        if (s1_sum_q == '0) begin
            res_d.zero = 1'b1;
        end else if (s1_sum_q[SUM_W-1]) begin
            // Right shift by one folds the dropped bit into the new LSB so
            // sticky information survives.
            shifted = {1'b0, s1_sum_q[SUM_W-1:2], s1_sum_q[1] | s1_sum_q[0]};
            if (exp_inc >= EXP_SAT) begin
                res_d.exp      = '1;
                res_d.overflow = 1'b1;
            end else begin
                res_d.exp  = exp_inc[EXP_W-1:0];
                res_d.frac = shifted[SUM_W-3:0];
            end
        end else if (s1_exp_q == '0) begin
            res_d.frac = s1_sum_q[SUM_W-3:0];
            if (s1_sum_q[SUM_W-2]) begin
                res_d.exp = EXP_W'(1);
            end else begin
                res_d.underflow = 1'b1;
            end
        end else if (lzc_ext < exp_ext) begin
            shifted    = s1_sum_q << lzc;
            res_d.exp  = exp_sub;
            res_d.frac = shifted[SUM_W-3:0];
        end else begin
            // Clamp to the subnormal range instead of letting the exponent wrap.
            shifted         = s1_sum_q << (s1_exp_q - EXP_W'(1));
            res_d.frac      = shifted[SUM_W-3:0];
            res_d.underflow = 1'b1;
        end
`ifdef FP_NORM_FTZ_EN
        if (res_d.underflow) begin
            res_d.exp  = '0;
            res_d.frac = '0;
            res_d.zero = 1'b1;
        end
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_sum_q    <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_sign_q <= bus.in_sign;
                    s1_exp_q  <= bus.in_exp;
                    s1_sum_q  <= bus.in_sum;
                end
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    res_q <= res_d;
                end
            end
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_sign      = res_q.sign;
    assign bus.out_exp       = res_q.exp;
    assign bus.out_frac      = res_q.frac;
    assign bus.out_zero      = res_q.zero;
    assign bus.out_underflow = res_q.underflow;
    assign bus.out_overflow  = res_q.overflow;

endmodule
